vend_dispense_arb: RTL and testbench
====================================

// Module: vend_dispense_arb
// PURPOSE
//  Shares one physical dispense mechanism (drink1 motor, drink2 motor, coin hopper) between
//  NREQ vending front-ends. Each front-end posts a finished sale (item + change owed in
//  0.5-units). The block grants requests round-robin and sequences timed motor/coin pulses.
//  It acks the requester when its transaction completes. Sits between seller FSMs and the
//  actuator drivers.
// PARAMETERS
//  NREQ      2  number of requesters (>=2)
//  PULSE_CYC 4  cycles each drink/coin pulse is held high (>=1)
//  GAP_CYC   2  low cycles after every pulse (>=1)
//  CHG_W     3  width of change count per requester
//  IDW       $clog2(NREQ)  grant index width (derived localparam)
// PORTS
//  clk        in   1          system clock, rising edge
//  rst        in   1          asynchronous, active-low reset
//  req        in   NREQ       per-requester request; held until its ack
//  item       in   2*NREQ     per-requester item code [2i+1:2i]: 00 change-only, 01 drink1, 10 drink2, 11 invalid
//  chg        in   NREQ*CHG_W per-requester change count, 0.5-units, [CHG_W*i +: CHG_W]
//  ack        out  NREQ       one-cycle completion pulse to granted requester
//  err        out  1          one-cycle pulse, coincident with ack, for item 11
//  busy       out  1          high from grant cycle+1 through ack cycle
//  gnt_id     out  IDW        index of current/last granted requester
//  drink1_pls out  1          drink1 motor drive
//  drink2_pls out  1          drink2 motor drive
//  coin_pls   out  1          coin hopper drive, one pulse per 0.5-unit
// BEHAVIOUR
//  Reset: all outputs 0; gnt_id=0; last-grant pointer=NREQ-1 (requester 0 wins first); FSM=IDLE.
//  All outputs registered. Reset mid-transaction aborts it: no ack, no further pulses.
//  FSM: IDLE, DRINK, DGAP, COIN, CGAP, DONE.
//  IDLE: pick first asserted req scanning from last+1 mod NREQ. Latch item, chg, gnt_id; update last.
//   item 01/10 -> DRINK. item 00, chg>0 -> COIN. item 00, chg=0 -> DONE. item 11 -> DONE with err.
//  DRINK: drinkN_pls high PULSE_CYC cycles -> DGAP.
//  DGAP: low GAP_CYC cycles -> COIN if chg>0, else DONE.
//  COIN: coin_pls high PULSE_CYC cycles, decrement latched chg -> CGAP.
//  CGAP: low GAP_CYC cycles -> COIN if remaining chg>0, else DONE.
//  DONE: one cycle: ack[gnt_id]=1, err if invalid -> IDLE.
//  Latency: request sampled at edge 0. First pulse spans cycles 1..PULSE_CYC.
//   Ack cycle = 1 + (D + chg)*(PULSE_CYC+GAP_CYC), where D=1 for drinks and 0 otherwise.
//   Ack cycle = 1 for item 11 and for change-only with chg=0.
//  Handshake: requester drops req the cycle after ack. In the IDLE cycle after DONE, the
//   just-acked requester's req is masked. item/chg are sampled only at grant.
//   Changes to them, or req dropped mid-transaction, are ignored; the transaction completes.
//  Simultaneous reqs: exactly one granted per IDLE; losers hold req and wait.
//   Worst-case wait is NREQ-1 transactions.
//  At most one of drink1_pls/drink2_pls/coin_pls is high in any cycle.
//  Phase counter sized for max(PULSE_CYC,GAP_CYC). Change counter is CHG_W bits with no wrap:
//   it only decrements when >0.
// CONFIGURATION
//  VEND_STATS_EN defined: adds output vend_cnt[15:0], total drinks dispensed.
//   Increments on the last DRINK cycle; saturates at 16'hFFFF; reset 0.
//  VEND_STATS_EN undefined: port and counter absent; all other behaviour identical.
// STRUCTURE
//  vend_pkg: item code constants (ITEM_CHG, ITEM_D1, ITEM_D2, ITEM_BAD), FSM state encodings.
//  Sub-module rr_pick: combinational round-robin picker.
//   Inputs: req vector, last pointer. Outputs: valid, index.
//  Instantiated once; FSM, counters and output regs live in vend_dispense_arb.
// TESTING
//  1 Reset, req[0]=1, item0=01, chg0=2 (P=4, G=2) -> drink1_pls cycles 1-4; coin_pls 7-10 and 13-16;
//    ack[0] at cycle 19; busy 1..19.
//  2 req=2'b11 same cycle, both item 10, chg 0 -> req0 served first (ack cycle 7).
//    req1 granted in the IDLE after, ack 8 cycles after first ack; next contest grants req0 again.
//  3 item0=11 -> ack[0]+err at cycle 1; no pulses. item0=00, chg0=0 -> ack at cycle 1, err=0.
//  4 item0=00, chg0=7 -> exactly 7 coin_pls pulses, no drink pulse; ack at cycle 43.
//  5 rst low during 2nd coin pulse -> all outputs 0 immediately; after release, a new req0 gets full service.
//  6 VEND_STATS_EN: 3 drink sales -> vend_cnt=3; preload 16'hFFFF -> stays FFFF; 1 change-only sale -> unchanged.

Source files
------------

// File: rtl/vend_pkg.sv
// Shared item codes and FSM state encoding for the vending dispense arbiter.
package vend_pkg;

  localparam logic [1:0] ITEM_CHG = 2'b00;
  localparam logic [1:0] ITEM_D1  = 2'b01;
  localparam logic [1:0] ITEM_D2  = 2'b10;
  localparam logic [1:0] ITEM_BAD = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_DRINK = 3'd1,
    S_DGAP  = 3'd2,
    S_COIN  = 3'd3,
    S_CGAP  = 3'd4,
    S_DONE  = 3'd5
  } vend_state_e;

endpackage

// File: rtl/vend_dispense_arb_rr_pick.sv
// Combinational round-robin picker: first asserted req scanning from last+1 (mod NREQ).
module rr_pick #(
  parameter  int unsigned NREQ = 2,
  localparam int unsigned IDW  = $clog2(NREQ)
) (
  input  logic [NREQ-1:0] req,
  input  logic [IDW-1:0]  last,
  output logic            valid_c,
  output logic [IDW-1:0]  idx_c
);

  // Scan offsets from farthest to nearest so the nearest hit after 'last' wins.
  always_comb begin
    valid_c = 1'b0;
    idx_c   = '0;
    for (int i = int'(NREQ); i >= 1; i--) begin
      for (int j = 0; j < int'(NREQ); j++) begin
        if ((j == ((int'(last) + i) % int'(NREQ))) && req[j]) begin
          valid_c = 1'b1;
          idx_c   = IDW'(j);
        end
      end
    end
  end

endmodule

// File: rtl/vend_dispense_arb.sv
// Round-robin arbiter sharing one drink/coin dispense mechanism between NREQ sellers.
// Optional VEND_STATS_EN adds vend_cnt, a saturating count of drinks dispensed.
module vend_dispense_arb
  import vend_pkg::*;
#(
  parameter  int unsigned NREQ      = 2,
  parameter  int unsigned PULSE_CYC = 4,
  parameter  int unsigned GAP_CYC   = 2,
  parameter  int unsigned CHG_W     = 3,
  localparam int unsigned IDW       = $clog2(NREQ)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [NREQ-1:0]       req,
  input  logic [2*NREQ-1:0]     item,
  input  logic [NREQ*CHG_W-1:0] chg,
  output logic [NREQ-1:0]       ack,
  output logic                  err,
  output logic                  busy,
  output logic [IDW-1:0]        gnt_id,
  output logic                  drink1_pls,
  output logic                  drink2_pls,
`ifdef VEND_STATS_EN
  output logic [15:0]           vend_cnt,
`endif
  output logic                  coin_pls
);

  localparam int unsigned MAXC = (PULSE_CYC > GAP_CYC) ? PULSE_CYC : GAP_CYC;
  localparam int unsigned PH_W = (MAXC > 1) ? $clog2(MAXC) : 1;
  localparam logic [PH_W-1:0] PH_PULSE_LAST = PH_W'(PULSE_CYC - 1);
  localparam logic [PH_W-1:0] PH_GAP_LAST   = PH_W'(GAP_CYC - 1);

  vend_state_e       state_q, state_d;
  logic [PH_W-1:0]   phase_q, phase_d;
  logic [1:0]        item_q, item_d;
  logic [CHG_W-1:0]  chg_q, chg_d;
  logic [IDW-1:0]    gnt_q, gnt_d;
  logic [IDW-1:0]    last_q, last_d;
  logic              mask_q, mask_d;
  logic [NREQ-1:0]   ack_q, ack_d;
  logic              err_q, err_d;
  logic              busy_q, busy_d;
  logic              d1_q, d1_d;
  logic              d2_q, d2_d;
  logic              coin_q, coin_d;

  logic [NREQ-1:0]   req_vis_c;
  logic              pick_valid_c;
  logic [IDW-1:0]    pick_idx_c;
  logic [1:0]        item_sel_c;
  logic [CHG_W-1:0]  chg_sel_c;

  // Hide the just-acked requester for the single IDLE cycle after DONE.
  always_comb begin
    req_vis_c = req;
    if (mask_q) req_vis_c = req & ~(NREQ'(1) << gnt_q);
  end

  rr_pick #(.NREQ(NREQ)) u_pick (
    .req     (req_vis_c),
    .last    (last_q),
    .valid_c (pick_valid_c),
    .idx_c   (pick_idx_c)
  );

  // Select the winning requester's item and change fields.
  always_comb begin
    item_sel_c = '0;
    chg_sel_c  = '0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (pick_idx_c == IDW'(i)) begin
        item_sel_c = item[2*i +: 2];
        chg_sel_c  = chg[CHG_W*i +: CHG_W];
      end
    end
  end

  // Next-state, phase/change counters, and next values of the registered outputs.
  always_comb begin
    state_d = state_q;
    phase_d = phase_q;
    item_d  = item_q;
    chg_d   = chg_q;
    gnt_d   = gnt_q;
    last_d  = last_q;
    mask_d  = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (pick_valid_c) begin
          gnt_d   = pick_idx_c;
          last_d  = pick_idx_c;
          item_d  = item_sel_c;
          chg_d   = chg_sel_c;
          phase_d = '0;
          case (item_sel_c)
            ITEM_D1, ITEM_D2: state_d = S_DRINK;
            ITEM_CHG:         state_d = (chg_sel_c != '0) ? S_COIN : S_DONE;
            default:          state_d = S_DONE;
          endcase
        end
      end
      S_DRINK: begin
        if (phase_q == PH_PULSE_LAST) begin
          phase_d = '0;
          state_d = S_DGAP;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_DGAP: begin
        if (phase_q == PH_GAP_LAST) begin
          phase_d = '0;
          state_d = (chg_q != '0) ? S_COIN : S_DONE;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_COIN: begin
        if (phase_q == PH_PULSE_LAST) begin
          phase_d = '0;
          if (chg_q != '0) chg_d = chg_q - CHG_W'(1);
          state_d = S_CGAP;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_CGAP: begin
        if (phase_q == PH_GAP_LAST) begin
          phase_d = '0;
          state_d = (chg_q != '0) ? S_COIN : S_DONE;
        end else begin
          phase_d = phase_q + PH_W'(1);
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        mask_d  = 1'b1;
      end
      default: state_d = S_IDLE;
    endcase

    ack_d  = (state_d == S_DONE) ? (NREQ'(1) << gnt_d) : '0;
    err_d  = (state_d == S_DONE) && (item_d == ITEM_BAD);
    busy_d = (state_d != S_IDLE);
    d1_d   = (state_d == S_DRINK) && (item_d == ITEM_D1);
    d2_d   = (state_d == S_DRINK) && (item_d == ITEM_D2);
    coin_d = (state_d == S_COIN);
  end

  // State, datapath and output registers.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q <= S_IDLE;
      phase_q <= '0;
      item_q  <= '0;
      chg_q   <= '0;
      gnt_q   <= '0;
      last_q  <= IDW'(NREQ - 1);
      mask_q  <= 1'b0;
      ack_q   <= '0;
      err_q   <= 1'b0;
      busy_q  <= 1'b0;
      d1_q    <= 1'b0;
      d2_q    <= 1'b0;
      coin_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      phase_q <= phase_d;
      item_q  <= item_d;
      chg_q   <= chg_d;
      gnt_q   <= gnt_d;
      last_q  <= last_d;
      mask_q  <= mask_d;
      ack_q   <= ack_d;
      err_q   <= err_d;
      busy_q  <= busy_d;
      d1_q    <= d1_d;
      d2_q    <= d2_d;
      coin_q  <= coin_d;
    end
  end

  assign ack        = ack_q;
  assign err        = err_q;
  assign busy       = busy_q;
  assign gnt_id     = gnt_q;
  assign drink1_pls = d1_q;
  assign drink2_pls = d2_q;
  assign coin_pls   = coin_q;

`ifdef VEND_STATS_EN
  logic [15:0] vend_cnt_q, vend_cnt_d;

  // Count drinks on the final DRINK cycle, saturating at all-ones.
  always_comb begin
    vend_cnt_d = vend_cnt_q;
    if ((state_q == S_DRINK) && (phase_q == PH_PULSE_LAST) && (vend_cnt_q != 16'hFFFF))
      vend_cnt_d = vend_cnt_q + 16'd1;
  end

  // Drink counter register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) vend_cnt_q <= '0;
    else      vend_cnt_q <= vend_cnt_d;
  end

  assign vend_cnt = vend_cnt_q;
`endif

endmodule

// File: tb/tb_vend_dispense_arb.sv
// Self-checking bench for vend_dispense_arb; define VEND_STATS_EN to also check vend_cnt.
module tb_vend_dispense_arb;

  localparam int unsigned NREQ = 2;
  localparam int unsigned PC   = 4;
  localparam int unsigned GC   = 2;
  localparam int unsigned CW   = 3;
  localparam int unsigned IDW  = $clog2(NREQ);

  logic                clk;
  logic                rst;
  logic [NREQ-1:0]     req;
  logic [2*NREQ-1:0]   item;
  logic [NREQ*CW-1:0]  chg;
  logic [NREQ-1:0]     ack;
  logic                err;
  logic                busy;
  logic [IDW-1:0]      gnt_id;
  logic                drink1_pls;
  logic                drink2_pls;
  logic                coin_pls;
`ifdef VEND_STATS_EN
  logic [15:0]         vend_cnt;
`endif

  int n_vec;
  int n_bad;
  int m_last;
  int m_drinks;

  vend_dispense_arb #(.NREQ(NREQ), .PULSE_CYC(PC), .GAP_CYC(GC), .CHG_W(CW)) dut (
    .clk        (clk),
    .rst        (rst),
    .req        (req),
    .item       (item),
    .chg        (chg),
    .ack        (ack),
    .err        (err),
    .busy       (busy),
    .gnt_id     (gnt_id),
    .drink1_pls (drink1_pls),
    .drink2_pls (drink2_pls),
`ifdef VEND_STATS_EN
    .vend_cnt   (vend_cnt),
`endif
    .coin_pls   (coin_pls)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] o, input logic [31:0] e);
    n_vec++;
    assert (o === e) else begin
      n_bad++;
      $error("FAIL %s: observed %0h expected %0h", tag, o, e);
    end
  endtask

  function automatic logic [31:0] obs();
    return 32'({ack, err, busy, drink1_pls, drink2_pls, coin_pls});
  endfunction

  // Ack cycle relative to the grant edge, straight from the latency rule.
  function automatic int ack_cycle(input int it, input int ch);
    int d;
    if (it == 3) return 1;
    d = (it == 1 || it == 2) ? 1 : 0;
    return 1 + (d + ch) * int'(PC + GC);
  endfunction

  // Expected {ack,err,busy,d1,d2,coin} in cycle t after the grant edge.
  function automatic logic [31:0] exp_vec(input int w, input int it, input int ch, input int t);
    logic [NREQ-1:0] a;
    logic e, d1, d2, c;
    int per, k, r;
    a = '0; e = 1'b0; d1 = 1'b0; d2 = 1'b0; c = 1'b0;
    per = int'(PC + GC);
    if (t == ack_cycle(it, ch)) begin
      a[w] = 1'b1;
      e    = (it == 3);
    end else begin
      k = (t - 1) / per;
      r = (t - 1) % per;
      if (r < int'(PC)) begin
        if (k == 0 && (it == 1 || it == 2)) begin
          d1 = (it == 1);
          d2 = (it == 2);
        end else begin
          c = 1'b1;
        end
      end
    end
    return 32'({a, e, 1'b1, d1, d2, c});
  endfunction

  // Round-robin winner: first pending requester after the last grant.
  function automatic int rr_win(input int last, input logic [NREQ-1:0] rq);
    for (int i = 1; i <= int'(NREQ); i++) begin
      if (rq[(last + i) % int'(NREQ)]) return (last + i) % int'(NREQ);
    end
    return -1;
  endfunction

  task automatic set_fields(input int i, input int it, input int ch);
    item[2*i +: 2] = 2'(it);
    chg[CW*i +: CW] = CW'(ch);
  endtask

  // Follow one granted transaction cycle by cycle up to its ack.
  task automatic check_txn(input int w, input int it, input int ch, input logic [NREQ-1:0] dm);
    int ackc;
    ackc   = ack_cycle(it, ch);
    m_last = w;
    for (int t = 1; t <= ackc; t++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("trace r%0d it%0d ch%0d t%0d", w, it, ch, t), obs(), exp_vec(w, it, ch, t));
      if (t == 1) begin
        chk("gnt_id", 32'(gnt_id), 32'(w));
        req = req & ~dm;
      end
      item[2*w +: 2]  = 2'($urandom);
      chg[CW*w +: CW] = CW'($urandom);
    end
    if (it == 1 || it == 2) m_drinks++;
`ifdef VEND_STATS_EN
    chk("vend_cnt", 32'(vend_cnt), 32'(m_drinks));
`endif
  endtask

  // Requester keeps req through the IDLE cycle after ack; it must not be re-granted.
  task automatic finish_hold(input int w);
    @(posedge clk);
    @(negedge clk);
    chk("post_ack_idle", obs(), 32'(0));
    @(posedge clk);
    @(negedge clk);
    chk("masked_rereq", obs(), 32'(0));
    req[w] = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    req = '0;
    @(negedge clk);
    rst = 1'b1;
    m_last   = int'(NREQ) - 1;
    m_drinks = 0;
    @(negedge clk);
  endtask

  initial begin
    logic [NREQ-1:0] pend;
    logic [NREQ-1:0] dm;
    int ri [NREQ];
    int rc [NREQ];
    int w;

    n_vec = 0; n_bad = 0;
    m_last = int'(NREQ) - 1; m_drinks = 0;
    rst = 1'b0; req = '0; item = '0; chg = '0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("reset_outs", obs(), 32'(0));
    chk("reset_gnt", 32'(gnt_id), 32'(0));
    rst = 1'b1;
    @(negedge clk);
    chk("idle_outs", obs(), 32'(0));

    // Drink1 with two coins of change
    set_fields(0, 1, 2);
    req = 2'b01;
    check_txn(0, 1, 2, '0);
    finish_hold(0);

    // Simultaneous drink2 requests from a fresh reset
    do_reset();
    set_fields(0, 2, 0);
    set_fields(1, 2, 0);
    req = 2'b11;
    w = rr_win(m_last, req);
    chk("contest1_win", 32'(w), 32'(0));
    check_txn(w, 2, 0, '0);
    @(posedge clk);
    @(negedge clk);
    chk("contest_gap", obs(), 32'(0));
    req[0] = 1'b0;
    w = rr_win(m_last, req);
    check_txn(w, 2, 0, '0);
    set_fields(0, 2, 0);
    req[0] = 1'b1;
    @(posedge clk);
    @(negedge clk);
    chk("contest_gap2", obs(), 32'(0));
    w = rr_win(m_last, req & ~(NREQ'(1) << m_last));
    check_txn(w, 2, 0, 2'b10);
    finish_hold(w);

    // Invalid item, then change-only with zero change
    set_fields(0, 3, 5);
    req = 2'b01;
    check_txn(0, 3, 5, '0);
    finish_hold(0);
    set_fields(0, 0, 0);
    req = 2'b01;
    check_txn(0, 0, 0, '0);
    finish_hold(0);

    // Maximum change, no drink
    set_fields(0, 0, 7);
    req = 2'b01;
    check_txn(0, 0, 7, '0);
    finish_hold(0);

    // Reset during the second coin pulse, then a full new sale
    set_fields(0, 0, 3);
    req = 2'b01;
    for (int t = 1; t <= 8; t++) begin
      @(posedge clk);
      @(negedge clk);
      chk($sformatf("pre_abort t%0d", t), obs(), exp_vec(0, 0, 3, t));
    end
    rst = 1'b0;
    req = '0;
    #1;
    chk("abort_outs", obs(), 32'(0));
    chk("abort_gnt", 32'(gnt_id), 32'(0));
`ifdef VEND_STATS_EN
    chk("abort_cnt", 32'(vend_cnt), 32'(0));
`endif
    m_last = int'(NREQ) - 1;
    m_drinks = 0;
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    chk("post_abort_idle", obs(), 32'(0));
    set_fields(0, 1, 1);
    req = 2'b01;
    check_txn(0, 1, 1, '0);
    finish_hold(0);

    // Randomized request patterns, fields and early req drops
    for (int n = 0; n < 16; n++) begin
      pend = NREQ'($urandom_range(1, (1 << NREQ) - 1));
      for (int i = 0; i < int'(NREQ); i++) begin
        ri[i] = $urandom_range(0, 3);
        rc[i] = $urandom_range(0, 7);
        if (pend[i]) set_fields(i, ri[i], rc[i]);
      end
      req = pend;
      while (pend != '0) begin
        w  = rr_win(m_last, pend);
        dm = ($urandom_range(0, 1) == 1) ? (NREQ'(1) << w) : '0;
        check_txn(w, ri[w], rc[w], dm);
        pend[w] = 1'b0;
        if (pend != '0) begin
          @(posedge clk);
          @(negedge clk);
          chk("handover_idle", obs(), 32'(0));
          req[w] = 1'b0;
        end else begin
          finish_hold(w);
        end
      end
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
